mac_acc_ctrl: RTL

Job sequencer for the four-lane MAC accumulator block. It accepts a job (mode config plus beat count) and loads the accumulator initial values. It then streams exactly that many operand beats through a valid/ready handshake, captures the final accumulator outputs into a result register, and presents them on a valid/ready result port. It sits between the MAC multiplier array and the accumulator block and owns that block's `en`, `cset` and `cfg` pins.

---
 rtl/mac_acc_ctrl_pkg.sv | 17 +
 rtl/mac_acc_ctrl_if.sv | 30 +++
 rtl/mac_acc_ctrl_beat_cnt.sv | 36 +++
 rtl/mac_acc_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mac_acc_ctrl_pkg.sv
// Shared types and config-field constants for the MAC accumulator job sequencer.
package mac_acc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_RESULT
    } state_t;

    localparam int         CFG_ACC_BIT = 2;
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

endpackage

// File: rtl/mac_acc_ctrl_if.sv
// Job, operand-stream and result handshakes of mac_acc_ctrl; master = job/data source, slave = sequencer.
interface mac_acc_ctrl_if #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int LEN_WIDTH      = 16
) ();

    logic                       start;
    logic [MAC_CONF_WIDTH-1:0]  start_cfg;
    logic [LEN_WIDTH-1:0]       start_len;
    logic                       busy;
    logic                       done;
    logic                       error;
    logic                       in_valid;
    logic                       in_ready;
    logic                       res_valid;
    logic                       res_ready;
    logic [4*MAC_ACC_WIDTH-1:0] res_data;

    modport master (
        output start, start_cfg, start_len, in_valid, res_ready,
        input  busy, done, error, in_ready, res_valid, res_data
    );

    modport slave (
        input  start, start_cfg, start_len, in_valid, res_ready,
        output busy, done, error, in_ready, res_valid, res_data
    );

endinterface

// File: rtl/mac_acc_ctrl_beat_cnt.sv
// Loadable down-counter holding the number of operand beats still owed by the current job.
module mac_acc_beat_cnt #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic [LEN_WIDTH-1:0] count,
    output logic                 zero
);

    logic [LEN_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/mac_acc_ctrl.sv
// Job sequencer for the four-lane MAC accumulator; owns the accumulator en/cset/cfg pins.
// Optional RUN-stall abort is compiled in with MAC_ACC_CTRL_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_LOAD   | one cycle, accumulator loads its initial values
// ST_RUN    | streaming operand beats until the count is exhausted
// ST_WAIT   | one cycle, capture accumulator outputs
// ST_RESULT | result presented until res_ready
module mac_acc_ctrl
    import mac_acc_ctrl_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    mac_acc_ctrl_if.slave              bus,
    output logic                       acc_en,
    output logic                       acc_cset,
    output logic [MAC_CONF_WIDTH-1:0]  acc_cfg,
    input  logic [4*MAC_ACC_WIDTH-1:0] acc_out
);

    state_t                     state_q, state_d;
    logic [MAC_CONF_WIDTH-1:0]  acc_cfg_q, acc_cfg_d;
    logic [4*MAC_ACC_WIDTH-1:0] res_data_q, res_data_d;
    logic                       busy_q, busy_d;
    logic                       in_ready_q, in_ready_d;
    logic                       cset_q, cset_d;
    logic                       res_valid_q, res_valid_d;
    logic                       error_q, error_d;
    logic                       start_acc, beat, timeout_hit, cnt_zero;
    logic [LEN_WIDTH-1:0]       cnt;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign beat      = (state_q == ST_RUN) && bus.in_valid;

    mac_acc_beat_cnt #(.LEN_WIDTH(LEN_WIDTH)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val (bus.start_len),
        .dec      (beat),
        .count    (cnt),
        .zero     (cnt_zero)
    );

`ifdef MAC_ACC_CTRL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = '0;
        if ((state_q == ST_RUN) && !bus.in_valid) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // Fires on the idle cycle that would bring the stall count to TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == ST_RUN) && !bus.in_valid &&
                         (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        acc_cfg_d  = acc_cfg_q;
        res_data_d = res_data_q;
        error_d    = error_q;
        if (start_acc) begin
            acc_cfg_d = bus.start_cfg;
            error_d   = 1'b0;
        end
        if (timeout_hit) begin
            error_d = 1'b1;
        end
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_LOAD;
            ST_LOAD:   state_d = cnt_zero ? ST_WAIT : ST_RUN;
            ST_RUN: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (beat && (cnt == LEN_WIDTH'(1))) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                res_data_d = acc_out;
                state_d    = ST_RESULT;
            end
            ST_RESULT: if (bus.res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_RUN);
        cset_d      = (state_d == ST_LOAD);
        res_valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_cfg_q   <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            cset_q      <= 1'b0;
            res_valid_q <= 1'b0;
            error_q     <= 1'b0;
`ifdef MAC_ACC_CTRL_TIMEOUT_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_cfg_q   <= acc_cfg_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            cset_q      <= cset_d;
            res_valid_q <= res_valid_d;
            error_q     <= error_d;
`ifdef MAC_ACC_CTRL_TIMEOUT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    // acc_en follows in_valid in RUN without a register so the beat lands on the same edge.
    assign acc_en        = cset_q | beat;
    assign acc_cset      = cset_q;
    assign acc_cfg       = acc_cfg_q;
    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.done      = (res_valid_q && bus.res_ready) || timeout_hit;
    assign bus.error     = error_q;

endmodule
